arith_unit_arbiter: RTL

//  Shares one multi-cycle multiplier and one divider between N_REQ requester FSMs
//  (interpolation FSM, solver step FSM, error estimator).

---
 rtl/arith_unit_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/arith_unit_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiplier and one divider among N_REQ requesters.
// Optional watchdog in WAIT is compiled in with `define ARB_TIMEOUT_EN.
module arith_unit_arbiter #(
  parameter int N_REQ          = 3,
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       op_div,
  input  logic [N_REQ*WIDTH-1:0] opa,
  input  logic [N_REQ*WIDTH-1:0] opb,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       req_done,
  output logic [WIDTH-1:0]       result,
  output logic                   busy,
  output logic                   timeout,
  output logic                   start_mul,
  output logic                   start_div,
  output logic [WIDTH-1:0]       unit_a,
  output logic [WIDTH-1:0]       unit_b,
  input  logic                   multiplier_done,
  input  logic                   divider_done,
  input  logic [WIDTH-1:0]       mul_result,
  input  logic [WIDTH-1:0]       div_result,
  output logic [1:0]             dbg_state
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW    = IDX_W + 1;

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("arith_unit_arbiter: N_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("arith_unit_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  // Handshake: req[i] is held high until req_done[i] pulses (or the requester gives up);
  // start_* and req_done are single-cycle pulses, *_done from the units is a level sampled in WAIT.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   req_done_q, req_done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic               start_mul_q, start_mul_d;
  logic               start_div_q, start_div_d;
  logic [WIDTH-1:0]   unit_a_q, unit_a_d;
  logic [WIDTH-1:0]   unit_b_q, unit_b_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               op_div_q, op_div_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [CW-1:0]      cand;
  logic               unit_done;
  logic [IDX_W-1:0]   owner_next;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  // Scan rr_ptr, rr_ptr+1, ... (mod N_REQ) and take the first requester found.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (!pick_found && req[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign unit_done  = op_div_q ? divider_done : multiplier_done;
  assign owner_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    req_done_d  = '0;
    result_d    = result_q;
    timeout_d   = 1'b0;
    start_mul_d = 1'b0;
    start_div_d = 1'b0;
    unit_a_d    = unit_a_q;
    unit_b_d    = unit_b_q;
    owner_d     = owner_q;
    op_div_d    = op_div_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d         = S_ISSUE;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          owner_d         = pick_idx;
          op_div_d        = op_div[pick_idx];
          unit_a_d        = opa[int'(pick_idx)*WIDTH +: WIDTH];
          unit_b_d        = opb[int'(pick_idx)*WIDTH +: WIDTH];
        end
      end
      S_ISSUE: begin
        start_mul_d = !op_div_q;
        start_div_d = op_div_q;
        state_d     = S_WAIT;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = '0;
`endif
      end
      S_WAIT: begin
        // Only the unit that was started can complete the op; the other done is noise.
        if (unit_done) begin
          result_d            = op_div_q ? div_result : mul_result;
          req_done_d[owner_q] = req[owner_q];
          gnt_d               = '0;
          state_d             = S_RELEASE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          gnt_d     = '0;
          state_d   = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_RELEASE: begin
        rr_ptr_d = owner_next;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      req_done_q  <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      start_mul_q <= 1'b0;
      start_div_q <= 1'b0;
      unit_a_q    <= '0;
      unit_b_q    <= '0;
      owner_q     <= '0;
      op_div_q    <= 1'b0;
      rr_ptr_q    <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      req_done_q  <= req_done_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      start_mul_q <= start_mul_d;
      start_div_q <= start_div_d;
      unit_a_q    <= unit_a_d;
      unit_b_q    <= unit_b_d;
      owner_q     <= owner_d;
      op_div_q    <= op_div_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign req_done  = req_done_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;
  assign start_mul = start_mul_q;
  assign start_div = start_div_q;
  assign unit_a    = unit_a_q;
  assign unit_b    = unit_b_q;
  assign dbg_state = state_q;

endmodule
